// File: rtl/control_logic.sv
// Control block of an 8259-style interrupt controller: ICW initialization sequencing,
// OCW command decode and the two-pulse INTA handshake that produces the vector byte.
module control_logic #(
    parameter logic [7:0] IMR_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] datatologic,
    input  logic [4:1] ICWs,
    input  logic [3:1] OCWs,
    input  logic       int_req,
    input  logic [2:0] int_level,
    input  logic       inta_n,
    output logic       INT,
    output logic       set_isr,
    output logic [2:0] ack_level,
    output logic [7:0] vector,
    output logic       vector_oe,
    output logic       eoi,
    output logic       eoi_specific,
    output logic [2:0] eoi_level,
    output logic [7:0] imr,
    output logic       ltim,
    output logic       aeoi,
    output logic       single,
    output logic [1:0] rd_sel,
    output logic       init_done
);
    typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} init_state_t;
    typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} inta_state_t;

    init_state_t init_state, init_next;
    inta_state_t inta_state, inta_next;

    logic       icw4_needed, icw4_needed_next;
    logic [4:0] base, base_next;
    logic       inta_prev;
    logic       aeoi_pend, aeoi_pend_next;
    logic       int_next, set_isr_next, vector_oe_next, eoi_next, eoi_specific_next;
    logic [2:0] ack_level_next, eoi_level_next;
    logic [7:0] vector_next, imr_next;
    logic       ltim_next, aeoi_next, single_next;
    logic [1:0] rd_sel_next;
    logic       inta_fall, inta_rise;
    logic       ocw_eoi, ocw_eoi_specific, aeoi_fire;

    assign inta_fall = inta_prev & ~inta_n;
    assign inta_rise = ~inta_prev & inta_n;
    assign init_done = (init_state == READY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_state   <= UNINIT;
            inta_state   <= IDLE;
            icw4_needed  <= 1'b0;
            base         <= 5'd0;
            inta_prev    <= 1'b1;
            aeoi_pend    <= 1'b0;
            INT          <= 1'b0;
            set_isr      <= 1'b0;
            ack_level    <= 3'd0;
            vector       <= 8'h00;
            vector_oe    <= 1'b0;
            eoi          <= 1'b0;
            eoi_specific <= 1'b0;
            eoi_level    <= 3'd0;
            imr          <= IMR_RESET;
            ltim         <= 1'b0;
            aeoi         <= 1'b0;
            single       <= 1'b0;
            rd_sel       <= 2'b01;
        end else begin
            init_state   <= init_next;
            inta_state   <= inta_next;
            icw4_needed  <= icw4_needed_next;
            base         <= base_next;
            inta_prev    <= inta_n;
            aeoi_pend    <= aeoi_pend_next;
            INT          <= int_next;
            set_isr      <= set_isr_next;
            ack_level    <= ack_level_next;
            vector       <= vector_next;
            vector_oe    <= vector_oe_next;
            eoi          <= eoi_next;
            eoi_specific <= eoi_specific_next;
            eoi_level    <= eoi_level_next;
            imr          <= imr_next;
            ltim         <= ltim_next;
            aeoi         <= aeoi_next;
            single       <= single_next;
            rd_sel       <= rd_sel_next;
        end
    end

    always_comb begin
        init_next         = init_state;
        inta_next         = inta_state;
        icw4_needed_next  = icw4_needed;
        base_next         = base;
        aeoi_pend_next    = 1'b0;
        int_next          = INT;
        set_isr_next      = 1'b0;
        ack_level_next    = ack_level;
        vector_next       = vector;
        vector_oe_next    = vector_oe;
        eoi_next          = 1'b0;
        eoi_specific_next = eoi_specific;
        eoi_level_next    = eoi_level;
        imr_next          = imr;
        ltim_next         = ltim;
        aeoi_next         = aeoi;
        single_next       = single;
        rd_sel_next       = rd_sel;
        ocw_eoi           = 1'b0;
        ocw_eoi_specific  = 1'b0;
        aeoi_fire         = aeoi_pend;

        // The ICW3 cascade byte has no consumer here; its strobe only advances the sequence.
        case (init_state)
            WAIT_ICW2: if (ICWs[2]) begin
                base_next = datatologic[7:3];
                if (!single)          init_next = WAIT_ICW3;
                else if (icw4_needed) init_next = WAIT_ICW4;
                else                  init_next = READY;
            end
            WAIT_ICW3: if (ICWs[3]) init_next = icw4_needed ? WAIT_ICW4 : READY;
            WAIT_ICW4: if (ICWs[4]) begin
                aeoi_next = datatologic[1];
                init_next = READY;
            end
            READY: begin
                if (OCWs[1]) imr_next = datatologic;
                if (OCWs[2]) begin
                    ocw_eoi          = (datatologic[7:5] == 3'b001) || (datatologic[7:5] == 3'b011);
                    ocw_eoi_specific = (datatologic[7:5] == 3'b011);
                end
                if (OCWs[3] && datatologic[1]) rd_sel_next = {datatologic[0], ~datatologic[0]};
            end
            default: ;
        endcase

        case (inta_state)
            IDLE: if (init_state == READY && int_req) begin
                inta_next = PEND;
                int_next  = 1'b1;
            end
            PEND: if (inta_fall) begin
                // A request that vanished before the acknowledge is reported as spurious level 7.
                ack_level_next = int_req ? int_level : 3'd7;
                set_isr_next   = 1'b1;
                int_next       = 1'b0;
                inta_next      = ACK1;
            end
            ACK1: if (inta_fall) begin
                vector_next    = {base, ack_level};
                vector_oe_next = 1'b1;
                inta_next      = ACK2;
            end
            ACK2: if (inta_rise) begin
                vector_oe_next = 1'b0;
                inta_next      = IDLE;
                if (aeoi) aeoi_fire = 1'b1;
            end
            default: inta_next = IDLE;
        endcase

        // A software EOI wins the shared eoi outputs; the automatic one retries next cycle.
        if (ocw_eoi) begin
            eoi_next          = 1'b1;
            eoi_specific_next = ocw_eoi_specific;
            if (ocw_eoi_specific) eoi_level_next = datatologic[2:0];
            aeoi_pend_next    = aeoi_fire;
        end else if (aeoi_fire) begin
            eoi_next          = 1'b1;
            eoi_specific_next = 1'b1;
            eoi_level_next    = ack_level;
        end

        if (ICWs[1]) begin
            ltim_next         = datatologic[3];
            single_next       = datatologic[1];
            icw4_needed_next  = datatologic[0];
            imr_next          = 8'h00;
            init_next         = WAIT_ICW2;
            inta_next         = IDLE;
            int_next          = 1'b0;
            set_isr_next      = 1'b0;
            vector_oe_next    = 1'b0;
            eoi_next          = 1'b0;
            eoi_specific_next = eoi_specific;
            eoi_level_next    = eoi_level;
            aeoi_pend_next    = 1'b0;
        end
    end
endmodule

// File: doc/control_logic.md
CONTROL_LOGIC -- requirements
Module: control_logic

Interface
REQ-001 SHALL have parameter IMR_RESET, default 8'hFF, mask register value after rst.
REQ-002 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port datatologic  in  8  command byte from the read/write stage, valid while any strobe is high.
REQ-005 SHALL have port ICWs  in  4 ([4:1])  one-hot, one-cycle strobes: ICW1..ICW4 present on datatologic.
REQ-006 SHALL have port OCWs  in  3 ([3:1])  one-hot, one-cycle strobes: OCW1..OCW3 present on datatologic.
REQ-007 SHALL have port int_req  in  1  priority resolver reports an unmasked pending request.
REQ-008 SHALL have port int_level  in  3  level of that request, valid with int_req.
REQ-009 SHALL have port inta_n  in  1  CPU interrupt acknowledge, active low, synchronous to clk.
REQ-010 SHALL have port INT  out  1  interrupt request to CPU.
REQ-011 SHALL have port set_isr  out  1  one-cycle pulse: set ISR bit ack_level.
REQ-012 SHALL have port ack_level  out  3  level frozen at first INTA.
REQ-013 SHALL have port vector  out  8  interrupt vector byte.
REQ-014 SHALL have port vector_oe  out  1  vector drives data bus.
REQ-015 SHALL have port eoi  out  1  one-cycle end-of-interrupt pulse.
REQ-016 SHALL have port eoi_specific  out  1  qualifies eoi; 1 = clear eoi_level only.
REQ-017 SHALL have port eoi_level  out  3  level for specific EOI.
REQ-018 SHALL have port imr  out  8  interrupt mask register.
REQ-019 SHALL have ports ltim, aeoi, single  out  1 each  ICW1[3], ICW4[1], ICW1[1] stored bits.
REQ-020 SHALL have port rd_sel  out  2  OCW3 read select (01 IRR, 10 ISR).
REQ-021 SHALL have port init_done  out  1  initialization sequence complete.

Function
REQ-022 Init FSM SHALL have states WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY, plus UNINIT after reset.
REQ-023 ICWs[1] in any state SHALL: store ltim/single/ICW4-needed, clear imr to 00, abort INTA FSM, clear INT, go WAIT_ICW2 next cycle.
REQ-024 ICWs[2] in WAIT_ICW2 SHALL store base = datatologic[7:3]; next state WAIT_ICW3 if single=0, else WAIT_ICW4 if ICW4 needed, else READY.
REQ-025 ICWs[3] in WAIT_ICW3 SHALL store byte; next WAIT_ICW4 if needed, else READY; ICWs[4] in WAIT_ICW4 SHALL store aeoi, go READY.
REQ-026 Strobes not matching current state SHALL be ignored (except ICW1); OCW strobes SHALL be ignored unless READY.
REQ-027 OCWs[1] SHALL load imr = datatologic the following cycle.
REQ-028 OCWs[2] with datatologic[7:5]=001 SHALL pulse eoi, eoi_specific=0; 011 SHALL pulse eoi, eoi_specific=1, eoi_level=datatologic[2:0]; other codes ignored.
REQ-029 OCWs[3] with datatologic[1]=1 SHALL load rd_sel = {datatologic[0], ~datatologic[0]}; otherwise rd_sel unchanged.
REQ-030 INTA FSM SHALL have states IDLE, PEND, ACK1, ACK2.
REQ-031 IDLE->PEND when READY and int_req=1; INT=1 registered, asserted the cycle after int_req seen.
REQ-032 Falling edge of inta_n (registered previous value 1, current 0) in PEND SHALL: freeze ack_level=int_level, pulse set_isr one cycle, clear INT, go ACK1.
REQ-033 If int_req drops in PEND before first INTA, FSM SHALL still acknowledge at int_level sampled at INTA edge; if int_req=0 at that edge, ack_level=7 (spurious).
REQ-034 Second falling edge in ACK1 SHALL go ACK2, vector = {base, ack_level}, vector_oe=1 while inta_n=0.
REQ-035 Rising edge of inta_n in ACK2 SHALL drop vector_oe, return IDLE, and pulse eoi (eoi_specific=1, eoi_level=ack_level) if aeoi=1.
REQ-036 Simultaneous OCW2 EOI and AEOI pulse SHALL give OCW2 priority; AEOI pulse deferred one cycle.
REQ-037 inta_n edges in IDLE SHALL be ignored.

Reset
REQ-038 rst=1 SHALL immediately force: UNINIT, IDLE, INT=0, set_isr=0, eoi=0, eoi_specific=0, eoi_level=0, ack_level=0, vector=00, vector_oe=0, imr=IMR_RESET, ltim=aeoi=single=0, rd_sel=01, init_done=0, base=0.
REQ-039 rst asserted mid-INTA SHALL drop vector_oe and INT in the same cycle asynchronously.

Verification
REQ-040 ICW1=13h, ICW2=40h, ICW4=03h strobes -> skips WAIT_ICW3, init_done=1, single=1, aeoi=1, imr=00.
REQ-041 ICW1=11h,ICW2=08h,ICW3=04h,ICW4=01h; int_req=1,level=5; two INTA pulses -> INT high then low at 1st edge, set_isr pulse with ack_level=5, vector=0Dh with vector_oe only during 2nd INTA low.
REQ-042 Same with aeoi=1 -> eoi pulse, eoi_specific=1, eoi_level=5 one cycle after 2nd INTA rises.
REQ-043 OCW1=A5h -> imr=A5h; OCW2=63h -> eoi, eoi_specific=1, eoi_level=3; OCW3=0Bh -> rd_sel=10.
REQ-044 ICW1 during ACK1 -> INT=0, vector_oe=0, state WAIT_ICW2, imr=00; OCW1 before init_done ignored.
REQ-045 rst pulse while vector_oe=1 -> all outputs at REQ-038 values without clk edge.
